// File: rtl/rr_req_pkg.sv
// Shared types and helpers for the requester-side frontend of the round-robin arbiter.
package rr_req_pkg;

  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_OWN  = 1'b1
  } req_state_e;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_HOLD  = 2;

  // Width of a client index; never collapses to zero bits for a single client.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_req_slot.sv
// Per-client pending-job counter: saturating at DEPTH, up on push, down on retire.
module rr_req_slot
  import rr_req_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic retire,
  output logic cnt_nz,
  output logic push_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] cnt_q, cnt_d;

  // A push landing with a retire swaps one job for another, so it is taken even at FULL.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !retire && (cnt_q != FULL)) begin
      cnt_d = cnt_q + CW'(1);
    end else if (retire && !push && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_nz     = (cnt_q != '0);
  assign push_ready = (cnt_q != FULL);

endmodule

// File: rtl/rr_requester_frontend.sv
// Queues client jobs, requests the arbiter, owns the resource HOLD cycles per grant, retires jobs.
module rr_requester_frontend
  import rr_req_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int HOLD  = DEFAULT_HOLD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         push,
  output logic [N-1:0]         push_ready,
  output logic [N-1:0]         req,
  input  logic [N-1:0]         grant,
  output logic                 owner_valid,
  output logic [id_w(N)-1:0]   owner_id,
  output logic [N-1:0]         done,
  output logic                 protocol_err
);

  localparam int IDW = id_w(N);
  localparam int HW  = (HOLD > 1) ? $clog2(HOLD) : 1;

  req_state_e       state_q;
  logic [HW-1:0]    hold_q;
  logic [IDW-1:0]   owner_q;
  logic             err_q;

  logic [N-1:0]     cnt_nz;
  logic [N-1:0]     retire_vec;
  logic             grant_onehot;
  logic             grant_live;
  logic [IDW-1:0]   grant_idx;
  logic             accept;
  logic             illegal;
  logic             last_cycle;

  always_comb begin
    grant_onehot = (grant != '0) && ((grant & (grant - N'(1))) == '0);
    grant_live   = |(grant & cnt_nz);
    grant_idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = IDW'(i);
    end
    accept     = (state_q == REQ_IDLE) && grant_onehot && grant_live;
    illegal    = (state_q == REQ_IDLE) && (grant != '0) && !(grant_onehot && grant_live);
    last_cycle = (state_q == REQ_OWN) && (hold_q == '0);
  end

  // Retire is suppressed under reset so an aborted job never signals done.
  always_comb begin
    retire_vec = '0;
    for (int i = 0; i < N; i++) begin
      retire_vec[i] = last_cycle && !reset && (owner_q == IDW'(i));
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_slot
    rr_req_slot #(
      .DEPTH (DEPTH)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .push       (push[g]),
      .retire     (retire_vec[g]),
      .cnt_nz     (cnt_nz[g]),
      .push_ready (push_ready[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REQ_IDLE;
      hold_q  <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        REQ_IDLE: begin
          if (accept) begin
            state_q <= REQ_OWN;
            owner_q <= grant_idx;
            hold_q  <= HW'(HOLD - 1);
          end
          if (illegal) err_q <= 1'b1;
        end
        REQ_OWN: begin
          if (hold_q == '0) begin
            state_q <= REQ_IDLE;
          end else begin
            hold_q <= hold_q - HW'(1);
          end
        end
        default: state_q <= REQ_IDLE;
      endcase
    end
  end

  assign req          = (state_q == REQ_IDLE) ? cnt_nz : '0;
  assign owner_valid  = (state_q == REQ_OWN);
  assign owner_id     = owner_q;
  assign done         = retire_vec;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_rr_requester_frontend.sv
// Bench for rr_requester_frontend with a holding round-robin arbiter model and a job-level reference.
module tb_rr_requester_frontend;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int HOLD  = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] push, push_ready, req, grant, done;
  logic         owner_valid;
  logic [1:0]   owner_id;
  logic         protocol_err;

  logic         force_en;
  logic [N-1:0] force_grant;
  logic [N-1:0] arb_grant_q;
  int           arb_ptr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign grant = force_en ? force_grant : arb_grant_q;

  rr_requester_frontend #(.N(N), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_ready   (push_ready),
    .req          (req),
    .grant        (grant),
    .owner_valid  (owner_valid),
    .owner_id     (owner_id),
    .done         (done),
    .protocol_err (protocol_err)
  );

  function automatic int arb_idx(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Registered arbiter: keeps a grant while its holder still requests, else rotates from the pointer.
  always @(posedge clk) begin
    if (reset) begin
      arb_grant_q <= '0;
      arb_ptr     <= 0;
    end else if ((arb_grant_q & req) != '0) begin
      arb_grant_q <= arb_grant_q;
    end else if (arb_idx(req, arb_ptr) >= 0) begin
      arb_grant_q <= N'(1) << arb_idx(req, arb_ptr);
      arb_ptr     <= (arb_idx(req, arb_ptr) + 1) % N;
    end else begin
      arb_grant_q <= '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; push = '0; force_en = 1'b0; force_grant = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; push = 4'b1111; force_en = 1'b0; force_grant = '0;
    tick(); tick();
    total++; if (req !== 4'b0000) begin bad++; $display("FAIL reset_req: got %b want 0000", req); end
    total++; if (push_ready !== 4'b1111) begin bad++; $display("FAIL reset_push_ready: got %b want 1111", push_ready); end
    total++; if (owner_valid !== 1'b0) begin bad++; $display("FAIL reset_owner_valid: got %b want 0", owner_valid); end
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL reset_done: got %b want 0000", done); end
    total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", protocol_err); end
    total++; if (owner_id !== 2'd0) begin bad++; $display("FAIL reset_owner_id: got %0d want 0", owner_id); end
    reset = 1'b0; push = '0;
    tick();
    total++; if (req !== 4'b0000) begin bad++; $display("FAIL reset_push_discarded: req got %b want 0000", req); end
  endtask

  task automatic test_single_job();
    do_reset();
    push = 4'b0100;
    tick();
    push = '0;
    total++; if (req !== 4'b0100) begin bad++; $display("FAIL single_req_c1: got %b want 0100", req); end
    tick();
    total++; if (owner_valid !== 1'b0) begin bad++; $display("FAIL single_valid_c2: got %b want 0", owner_valid); end
    tick();
    total++; if (owner_valid !== 1'b1 || owner_id !== 2'd2) begin bad++; $display("FAIL single_own_c3: got v=%b id=%0d want v=1 id=2", owner_valid, owner_id); end
    total++; if (done !== 4'b0000 || req !== 4'b0000) begin bad++; $display("FAIL single_c3: got done=%b req=%b want 0000 0000", done, req); end
    tick();
    total++; if (owner_valid !== 1'b1 || owner_id !== 2'd2) begin bad++; $display("FAIL single_own_c4: got v=%b id=%0d want v=1 id=2", owner_valid, owner_id); end
    total++; if (done !== 4'b0100) begin bad++; $display("FAIL single_done_c4: got %b want 0100", done); end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (req !== 4'b0000 || owner_valid !== 1'b0 || done !== 4'b0000) begin
        bad++; $display("FAIL single_after: got req=%b v=%b done=%b want 0000 0 0000", req, owner_valid, done);
      end
    end
  endtask

  task automatic test_full_fanin();
    int owners[$];
    int dones;
    int viol;
    logic prev_valid;
    dones = 0; viol = 0; prev_valid = 1'b0;
    do_reset();
    push = 4'b1111;
    tick();
    push = '0;
    for (int c = 0; c < 40; c++) begin
      if (owner_valid && !prev_valid) owners.push_back(int'(owner_id));
      dones += $countones(done);
      if (owner_valid && req != '0) viol++;
      prev_valid = owner_valid;
      tick();
    end
    total++; if (owners.size() != 4) begin bad++; $display("FAIL fanin_ownerships: got %0d want 4", owners.size()); end
    for (int k = 0; k < owners.size() && k < 4; k++) begin
      total++; if (owners[k] != k) begin bad++; $display("FAIL fanin_order[%0d]: got %0d want %0d", k, owners[k], k); end
    end
    total++; if (dones != 4) begin bad++; $display("FAIL fanin_done_count: got %0d want 4", dones); end
    total++; if (viol != 0) begin bad++; $display("FAIL fanin_req_during_own: got %0d cycles want 0", viol); end
  endtask

  task automatic test_depth_boundary();
    int dones;
    dones = 0;
    do_reset();
    force_en = 1'b1; force_grant = '0;
    for (int k = 0; k < 5; k++) begin
      push = 4'b0001;
      tick();
      total++; if (push_ready[0] !== (k < 3)) begin
        bad++; $display("FAIL depth_ready_after_%0d: got %b want %b", k + 1, push_ready[0], (k < 3));
      end
    end
    push = '0;
    tick();
    force_en = 1'b0;
    for (int c = 0; c < 60; c++) begin
      dones += int'(done[0]);
      tick();
    end
    total++; if (dones != 4) begin bad++; $display("FAIL depth_done_count: got %0d want 4", dones); end
    total++; if (push_ready[0] !== 1'b1 || req !== 4'b0000) begin
      bad++; $display("FAIL depth_drained: got ready=%b req=%b want 1 0000", push_ready[0], req);
    end
  endtask

  task automatic test_illegal_grant();
    do_reset();
    force_en = 1'b1; force_grant = '0;
    push = 4'b0011;
    tick();
    push = '0;
    total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL illegal_zero_grant: err got %b want 0", protocol_err); end
    force_grant = 4'b0011;
    tick();
    force_grant = '0;
    total++; if (protocol_err !== 1'b1 || owner_valid !== 1'b0) begin
      bad++; $display("FAIL illegal_multi: got err=%b v=%b want 1 0", protocol_err, owner_valid);
    end
    tick();
    total++; if (protocol_err !== 1'b1 || owner_valid !== 1'b0) begin
      bad++; $display("FAIL illegal_sticky: got err=%b v=%b want 1 0", protocol_err, owner_valid);
    end
    force_grant = 4'b1000;
    tick();
    force_grant = '0;
    total++; if (owner_valid !== 1'b0 || protocol_err !== 1'b1) begin
      bad++; $display("FAIL illegal_empty_client: got v=%b err=%b want 0 1", owner_valid, protocol_err);
    end
    do_reset();
    total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL illegal_cleared: err got %b want 0", protocol_err); end
    force_en = 1'b1; force_grant = 4'b1000;
    tick();
    force_grant = '0;
    total++; if (owner_valid !== 1'b0 || protocol_err !== 1'b1) begin
      bad++; $display("FAIL illegal_fresh_empty: got v=%b err=%b want 0 1", owner_valid, protocol_err);
    end
    force_en = 1'b0;
  endtask

  task automatic test_reset_mid_own();
    int waited;
    waited = 0;
    do_reset();
    push = 4'b0010;
    tick(); tick();
    push = '0;
    while (!owner_valid && waited < 10) begin
      tick();
      waited++;
    end
    total++; if (!owner_valid) begin
      bad++; $display("FAIL midown_no_ownership: got v=%b want 1 within 10 cycles", owner_valid);
    end else begin
      tick();
      reset = 1'b1;
      #1;
      total++; if (done !== 4'b0000) begin bad++; $display("FAIL midown_done_pulse: got %b want 0000", done); end
      tick();
      total++; if (owner_valid !== 1'b0 || req !== 4'b0000 || push_ready !== 4'b1111) begin
        bad++; $display("FAIL midown_after: got v=%b req=%b ready=%b want 0 0000 1111", owner_valid, req, push_ready);
      end
      reset = 1'b0;
      tick(); tick();
      total++; if (req !== 4'b0000 || owner_valid !== 1'b0) begin
        bad++; $display("FAIL midown_cleared: got req=%b v=%b want 0000 0", req, owner_valid);
      end
    end
  endtask

  task automatic test_random();
    int mcnt[N];
    int own_left;
    int mowner;
    logic merr;
    logic [N-1:0] p, exp_req, exp_ready, exp_done;
    logic retire;
    int gidx;
    own_left = 0; mowner = 0; merr = 1'b0;
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        exp_req[i]   = (own_left == 0) && (mcnt[i] > 0);
        exp_ready[i] = (mcnt[i] < DEPTH);
        exp_done[i]  = (own_left == 1) && (mowner == i);
      end
      total++; if (req !== exp_req) begin bad++; $display("FAIL rand_req@%0d: got %b want %b", cyc, req, exp_req); end
      total++; if (push_ready !== exp_ready) begin bad++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, push_ready, exp_ready); end
      total++; if (owner_valid !== (own_left > 0)) begin bad++; $display("FAIL rand_valid@%0d: got %b want %b", cyc, owner_valid, (own_left > 0)); end
      if (own_left > 0) begin
        total++; if (owner_id !== 2'(mowner)) begin bad++; $display("FAIL rand_owner@%0d: got %0d want %0d", cyc, owner_id, mowner); end
      end
      total++; if (done !== exp_done) begin bad++; $display("FAIL rand_done@%0d: got %b want %b", cyc, done, exp_done); end
      total++; if (protocol_err !== merr) begin bad++; $display("FAIL rand_err@%0d: got %b want %b", cyc, protocol_err, merr); end

      for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 3) == 0);
      retire = (own_left == 1);
      gidx = -1;
      for (int i = 0; i < N; i++) if (grant[i]) gidx = i;
      if (own_left > 0) begin
        own_left--;
      end else if (grant != '0) begin
        if ($countones(grant) == 1 && mcnt[gidx] > 0) begin
          own_left = HOLD;
          mowner   = gidx;
        end else begin
          merr = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (p[i] && retire && (i == mowner)) mcnt[i] = mcnt[i];
        else if (p[i] && mcnt[i] < DEPTH) mcnt[i]++;
        else if (!p[i] && retire && (i == mowner)) mcnt[i]--;
      end
      push = p;
      tick();
    end
    push = '0;
  endtask

  initial begin
    reset = 1'b1; push = '0; force_en = 1'b0; force_grant = '0;
    test_reset();
    test_single_job();
    test_full_fanin();
    test_depth_boundary();
    test_illegal_grant();
    test_reset_mid_own();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
